// File: rtl/lin_mask_counter.sv
// Multi-mask linear-approximation hit counter: message-side parities wait in a FIFO until the matching ciphertext arrives.
// Optional status outputs (err, fifo_level) are enabled by defining LIN_MASK_COUNTER_STATUS_EN.
module lin_mask_counter #(
    parameter int DATA_W       = 64,
    parameter int NUM_MASKS    = 4,
    parameter int NUM_MESSAGES = 1024,
    parameter int FIFO_DEPTH   = 32,
    localparam int CNT_W       = $clog2(NUM_MESSAGES + 1),
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_MASKS*DATA_W-1:0]   mask_i,
    input  logic [NUM_MASKS*DATA_W-1:0]   mask_o,
    input  logic                          msg_valid,
    input  logic [DATA_W-1:0]             message,
    output logic                          msg_ready,
    input  logic                          ct_valid,
    input  logic [DATA_W-1:0]             ciphertext,
    output logic [NUM_MASKS*CNT_W-1:0]    counter,
    output logic                          busy,
    output logic                          valid
`ifdef LIN_MASK_COUNTER_STATUS_EN
    ,
    output logic [1:0]                    err,
    output logic [LVL_W-1:0]              fifo_level
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                         state_reg;
    logic [NUM_MASKS*DATA_W-1:0]    mask_i_reg;
    logic [NUM_MASKS*DATA_W-1:0]    mask_o_reg;
    logic [NUM_MASKS-1:0]           fifo_mem [FIFO_DEPTH];
    logic [AW:0]                    wr_ptr_reg;
    logic [AW:0]                    rd_ptr_reg;
    logic [CNT_W-1:0]               acc_cnt_reg;
    logic [CNT_W-1:0]               cons_cnt_reg;
    logic [NUM_MASKS-1:0]           hit_reg;
    logic                           hit_valid_reg;
    logic                           hit_last_reg;
    logic [NUM_MASKS*CNT_W-1:0]     counter_reg;
    logic                           busy_reg;
    logic                           valid_reg;
    logic                           msg_ready_reg;

    logic [NUM_MASKS-1:0]           msg_par;
    logic [NUM_MASKS-1:0]           ct_par;
    logic                           fifo_empty;
    logic                           fifo_full;
    logic                           accept;
    logic                           pop;
    logic                           push;

    generate
        for (genvar gi = 0; gi < NUM_MASKS; gi++) begin : g_par
            assign msg_par[gi] = ^(message    & mask_i_reg[gi*DATA_W +: DATA_W]);
            assign ct_par[gi]  = ^(ciphertext & mask_o_reg[gi*DATA_W +: DATA_W]);
        end
    endgenerate

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign accept     = msg_valid & msg_ready_reg;
    assign pop        = (state_reg == RUN) & ct_valid & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push       = accept & (~fifo_full | pop);

    // Storage has no reset; the read is combinational because its result is registered into hit_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[AW-1:0]] <= msg_par;
        end
    end

`ifdef LIN_MASK_COUNTER_STATUS_EN
    logic [1:0] err_reg;
    logic       overflow;
    logic       underflow;

    assign overflow   = accept & fifo_full & ~pop;
    assign underflow  = (state_reg == RUN) & ct_valid & fifo_empty;
    assign err        = err_reg;
    assign fifo_level = wr_ptr_reg - rd_ptr_reg;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            mask_i_reg    <= '0;
            mask_o_reg    <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            acc_cnt_reg   <= '0;
            cons_cnt_reg  <= '0;
            hit_reg       <= '0;
            hit_valid_reg <= 1'b0;
            hit_last_reg  <= 1'b0;
            counter_reg   <= '0;
            busy_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            msg_ready_reg <= 1'b0;
`ifdef LIN_MASK_COUNTER_STATUS_EN
            err_reg       <= 2'b00;
`endif
        end else if (start && state_reg != RUN) begin
            state_reg     <= RUN;
            mask_i_reg    <= mask_i;
            mask_o_reg    <= mask_o;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            acc_cnt_reg   <= '0;
            cons_cnt_reg  <= '0;
            hit_valid_reg <= 1'b0;
            hit_last_reg  <= 1'b0;
            counter_reg   <= '0;
            busy_reg      <= 1'b1;
            valid_reg     <= 1'b0;
            msg_ready_reg <= 1'b1;
`ifdef LIN_MASK_COUNTER_STATUS_EN
            err_reg       <= 2'b00;
`endif
        end else if (state_reg == RUN) begin
            if (accept) begin
                acc_cnt_reg <= acc_cnt_reg + CNT_W'(1);
                if (acc_cnt_reg == CNT_W'(NUM_MESSAGES - 1)) begin
                    msg_ready_reg <= 1'b0;
                end
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + (AW+1)'(1);
                cons_cnt_reg <= cons_cnt_reg + CNT_W'(1);
                hit_reg      <= fifo_mem[rd_ptr_reg[AW-1:0]] ^ ct_par;
            end
            hit_valid_reg <= pop;
            hit_last_reg  <= pop && (cons_cnt_reg == CNT_W'(NUM_MESSAGES - 1));
            if (hit_valid_reg) begin
                for (int k = 0; k < NUM_MASKS; k++) begin
                    counter_reg[k*CNT_W +: CNT_W] <= counter_reg[k*CNT_W +: CNT_W] + CNT_W'(hit_reg[k]);
                end
            end
            // The run closes on the edge that folds in the final hit.
            if (hit_last_reg) begin
                state_reg <= DONE;
                busy_reg  <= 1'b0;
                valid_reg <= 1'b1;
            end
`ifdef LIN_MASK_COUNTER_STATUS_EN
            if (overflow) begin
                err_reg[0] <= 1'b1;
            end
            if (underflow) begin
                err_reg[1] <= 1'b1;
            end
`endif
        end
    end

    assign counter   = counter_reg;
    assign busy      = busy_reg;
    assign valid     = valid_reg;
    assign msg_ready = msg_ready_reg;

endmodule

// File: tb/tb_lin_mask_counter.sv
// Bench for lin_mask_counter: table of runs replayed against a scoreboard, plus reset, abort, underflow and overflow sequences.
module tb_lin_mask_counter;

    localparam int DW   = 64;
    localparam int NM   = 4;
    localparam int NMSG = 32;
    localparam int FD   = 8;
    localparam int CW   = $clog2(NMSG + 1);
    localparam int LW   = $clog2(FD) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NM*DW-1:0]  mask_i = '0;
    logic [NM*DW-1:0]  mask_o = '0;
    logic              msg_valid = 1'b0;
    logic [DW-1:0]     message = '0;
    logic              msg_ready;
    logic              ct_valid = 1'b0;
    logic [DW-1:0]     ciphertext = '0;
    logic [NM*CW-1:0]  counter;
    logic              busy;
    logic              valid;
`ifdef LIN_MASK_COUNTER_STATUS_EN
    logic [1:0]        err;
    logic [LW-1:0]     fifo_level;
`endif

    always #5 clk = ~clk;

    lin_mask_counter #(
        .DATA_W(DW), .NUM_MASKS(NM), .NUM_MESSAGES(NMSG), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mask_i(mask_i), .mask_o(mask_o),
        .msg_valid(msg_valid), .message(message), .msg_ready(msg_ready),
        .ct_valid(ct_valid), .ciphertext(ciphertext),
        .counter(counter), .busy(busy), .valid(valid)
`ifdef LIN_MASK_COUNTER_STATUS_EN
        , .err(err), .fifo_level(fifo_level)
`endif
    );

    typedef struct {
        logic [DW-1:0] ct;
        logic [NM-1:0] hits;
        int            ready;
    } pend_t;

    typedef struct {
        int            due;
        logic [NM*CW-1:0] cnt;
    } exp_t;

    typedef struct {
        logic [NM*DW-1:0] mi;
        logic [NM*DW-1:0] mo;
        int               msg_mode;
        int               ct_mode;
        int               lat;
        int               max_gap;
        int               duty;
        logic [63:0]      seed;
        bit               fixed;
        logic [NM*CW-1:0] exp;
    } vec_t;

    pend_t            pend_q[$];
    exp_t             exp_q[$];
    logic [NM*CW-1:0] run_q[$];
    vec_t             vecs[4];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    function automatic bit par(input logic [63:0] v);
        bit p = 1'b0;
        for (int i = 0; i < 64; i++) p ^= v[i];
        return p;
    endfunction

    function automatic logic [63:0] lfsr_next(input logic [63:0] x);
        return x[0] ? ((x >> 1) ^ 64'hD800_0000_0000_0000) : (x >> 1);
    endfunction

    function automatic logic [63:0] gen_msg(input logic [63:0] x, input int mode);
        logic [63:0] m = x;
        if (mode == 1) m[1] = ~m[0];
        return m;
    endfunction

    function automatic logic [63:0] ctfun(input logic [63:0] m, input int mode);
        if (mode == 0) return m;
        return {m[40:0], m[63:41]} ^ (m >> 7) ^ 64'h0F1E_2D3C_4B5A_6978;
    endfunction

    function automatic logic [NM-1:0] calc_hits(input logic [63:0] m, input logic [63:0] c,
                                                input logic [NM*DW-1:0] mi, input logic [NM*DW-1:0] mo);
        logic [NM-1:0] h;
        for (int k = 0; k < NM; k++) h[k] = par(m & mi[k*DW +: DW]) ^ par(c & mo[k*DW +: DW]);
        return h;
    endfunction

    function automatic logic [NM*CW-1:0] add_hits(input logic [NM*CW-1:0] c, input logic [NM-1:0] h);
        logic [NM*CW-1:0] r = c;
        for (int k = 0; k < NM; k++) r[k*CW +: CW] = r[k*CW +: CW] + CW'(h[k]);
        return r;
    endfunction

    task automatic check_due();
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            check("running_counter", counter, exp_q[0].cnt);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic do_start(input logic [NM*DW-1:0] mi, input logic [NM*DW-1:0] mo);
        mask_i = mi;
        mask_o = mo;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("start_counter", counter, '0);
        check("start_flags", {busy, valid, msg_ready}, 3'b101);
    endtask

    task automatic run_vector(input vec_t v, input int abort_at);
        int acc = 0, sent = 0, gap = 0, t0;
        logic [NM*CW-1:0] model = '0;
        logic [63:0] lf = v.seed;
        logic [63:0] m, c;
        bit mv;
        pend_q.delete();
        exp_q.delete();
        do_start(v.mi, v.mo);
        t0 = cyc;
        while (sent < NMSG) begin
            if (cyc - t0 > 2000) begin
                checks++;
                errors++;
                $display("FAIL run_timeout: sent %0d of %0d ciphertexts, accepted %0d", sent, NMSG, acc);
                break;
            end
            check_due();
            if (abort_at > 0 && acc == abort_at) break;
            m  = gen_msg(lf, v.msg_mode);
            mv = ((acc - sent) < FD - 2) && ($urandom_range(0, 99) < v.duty);
            msg_valid = mv;
            message   = m;
            if (mv && msg_ready) begin
                acc++;
                c = ctfun(m, v.ct_mode);
                pend_q.push_back('{ct: c, hits: calc_hits(m, c, v.mi, v.mo), ready: cyc + v.lat});
                lf = lfsr_next(lf);
            end
            if (gap == 0 && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
                ct_valid   = 1'b1;
                ciphertext = pend_q[0].ct;
                model      = add_hits(model, pend_q[0].hits);
                exp_q.push_back('{due: cyc + 2, cnt: model});
                void'(pend_q.pop_front());
                sent++;
                gap = $urandom_range(0, v.max_gap);
                if (sent == NMSG) run_q.push_back(v.fixed ? v.exp : model);
            end else begin
                ct_valid = 1'b0;
                if (gap > 0) gap--;
            end
            tick();
        end
        msg_valid = 1'b0;
        ct_valid  = 1'b0;
        if (abort_at > 0) return;
        check_due();
        check("msg_ready_low", msg_ready, 1'b0);
        check("accepted", acc, NMSG);
        check("valid_early", valid, 1'b0);
        tick();
        check_due();
        check("done_flags", {valid, busy}, 2'b10);
        if (run_q.size() > 0) check("final_counter", counter, run_q.pop_front());
    endtask

    initial begin
        logic [63:0] ones = 64'hFFFF_FFFF_FFFF_FFFF;
        logic [63:0] msb  = 64'h8000_0000_0000_0000;
        logic [63:0] ov_msg[FD+1];
        logic [63:0] lf;
        logic [NM*CW-1:0] model;
        logic [NM-1:0] h;

        vecs[0] = '{{ones, msb, 64'h1, 64'h0}, {ones, msb, 64'h1, 64'h0},
                    0, 0, 3, 0, 100, 64'h0123_4567_89AB_CDEF, 1'b1, '0};
        vecs[1] = '{{ones, msb, 64'h1, 64'h0}, {ones, msb, 64'h2, 64'h0},
                    1, 0, 3, 0, 100, 64'h5A5A_1234_DEAD_BEEF, 1'b1,
                    {CW'(0), CW'(0), CW'(NMSG), CW'(0)}};
        vecs[2] = '{{64'h0123_4567_89AB_CDEF, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0000_FFFF_0000_FFFF, 64'h1584_4589_2548_4615},
                    {64'hFEDC_BA98_7654_3210, 64'h3333_3333_3333_3333, 64'h5555_5555_5555_5555, 64'h0049_8451_7478_9897},
                    0, 1, 6, 0, 100, 64'h1357_9BDF_0246_8ACE, 1'b0, '0};
        vecs[3] = '{{64'hA5A5_0000_FFFF_1111, 64'h0F0F_0F0F_0000_0001, 64'h8421_8421_8421_8421, 64'hC3C3_3C3C_C3C3_3C3C},
                    {64'h1111_2222_4444_8888, 64'h7777_0000_7777_0000, 64'h0000_0000_0000_0003, 64'hDEAD_BEEF_CAFE_F00D},
                    0, 1, 2, 5, 70, 64'h2468_ACE0_1357_9BDF, 1'b0, '0};

        // Reset held two cycles, then idle traffic without start.
        @(negedge clk);
        tick();
        tick();
        check("reset_counter", counter, '0);
        check("reset_flags", {busy, valid, msg_ready}, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            msg_valid  = i[0];
            ct_valid   = ~i[0];
            message    = {$urandom, $urandom};
            ciphertext = {$urandom, $urandom};
            tick();
            check("idle_counter", counter, '0);
            check("idle_flags", {busy, valid, msg_ready}, 3'b000);
        end
        msg_valid = 1'b0;
        ct_valid  = 1'b0;

        // Table runs; the second and later ones restart from DONE.
        for (int i = 0; i < 3; i++) run_vector(vecs[i], 0);

        // Abort mid-run.
        run_vector(vecs[3], 20);
        rst_n = 1'b0;
        tick();
        check("abort_counter", counter, '0);
        check("abort_flags", {busy, valid, msg_ready}, 3'b000);
        rst_n = 1'b1;
        exp_q.delete();
        pend_q.delete();
        run_q.delete();

        // Underflow: ciphertexts with an empty FIFO are ignored.
        do_start(vecs[3].mi, vecs[3].mo);
        ct_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ciphertext = {$urandom, $urandom};
            tick();
        end
        ct_valid = 1'b0;
        tick();
        tick();
        check("underflow_counter", counter, '0);
`ifdef LIN_MASK_COUNTER_STATUS_EN
        check("underflow_err", err, 2'b10);
`endif

        // Overflow: FD+1 messages before any ciphertext, the last write is lost.
        lf = 64'h0BAD_F00D_1234_5678;
        for (int i = 0; i <= FD; i++) begin
            ov_msg[i] = gen_msg(lf, 0);
            lf        = lfsr_next(lf);
            msg_valid = 1'b1;
            message   = ov_msg[i];
            tick();
        end
        msg_valid = 1'b0;
        check("overflow_ready", msg_ready, 1'b1);
`ifdef LIN_MASK_COUNTER_STATUS_EN
        check("overflow_err", err, 2'b11);
        check("overflow_level", fifo_level, LW'(FD));
`endif
        model = '0;
        for (int i = 0; i <= FD; i++) begin
            ct_valid   = 1'b1;
            ciphertext = ctfun(ov_msg[i], 1);
            h = calc_hits(ov_msg[i], ciphertext, vecs[3].mi, vecs[3].mo);
            if (i < FD) model = add_hits(model, h);
            tick();
        end
        ct_valid = 1'b0;
        tick();
        tick();
        check("overflow_counter", counter, model);
        check("overflow_stuck", {busy, valid}, 2'b10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Full runs from IDLE after reset, with gaps and bursty messages.
        run_vector(vecs[3], 0);
        run_vector(vecs[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lin_mask_counter.md
# lin_mask_counter

Parametrised linear-approximation counter for the DES cryptanalysis datapath. It takes a stream of plaintext words and the matching stream of ciphertext words from a pipelined encryption core with any fixed or variable latency. For each of `NUM_MASKS` (input mask, output mask) pairs it counts how many of `NUM_MESSAGES` pairs satisfy parity(message & mask_i) ^ parity(ciphertext & mask_o) = 1. It sits between the message generator / encryption core and the result collection logic, and replaces the single-mask, fixed-delay counter block.

## Interface
Parameters:
- `DATA_W`, 64: message/ciphertext width.
- `NUM_MASKS`, 4: number of mask pairs evaluated in parallel (≥1).
- `NUM_MESSAGES`, 1024: pairs processed per run (≥1).
- `FIFO_DEPTH`, 32: parity FIFO depth; power of two, ≥ core latency + 2.
- `CNT_W`, $clog2(NUM_MESSAGES+1): counter width (derived, not overridden).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `start` in 1: begin a run; masks are sampled on the same cycle.
- `mask_i` in NUM_MASKS*DATA_W: input masks, mask k at [k*DATA_W +: DATA_W].
- `mask_o` in NUM_MASKS*DATA_W: output masks, same packing.
- `msg_valid` in 1: `message` valid this cycle.
- `message` in DATA_W: plaintext word.
- `msg_ready` out 1: block accepts messages (RUN and fewer than NUM_MESSAGES accepted).
- `ct_valid` in 1: `ciphertext` valid this cycle.
- `ciphertext` in DATA_W: ciphertext word, in message order.
- `counter` out NUM_MASKS*CNT_W: hit counts, counter k at [k*CNT_W +: CNT_W].
- `busy` out 1: high in RUN.
- `valid` out 1: counts final, high in DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
  - IDLE → RUN on `start`.
  - RUN → DONE when the NUM_MESSAGES-th ciphertext has been counted.
  - DONE → RUN on `start` (restart). Otherwise DONE holds.
  - `start` in RUN is ignored.
- On `start`, the following happen in the same edge:
  - latch `mask_i` and `mask_o` into internal registers;
  - clear all counters, the accepted/consumed counters and the FIFO pointers.
- Message side:
  - A message is accepted when `msg_valid & msg_ready`.
  - On acceptance, the NUM_MASKS-bit vector of parity(message & mask_i_k) is written to the FIFO.
  - `msg_valid` while `msg_ready` is low is dropped.
- Ciphertext side:
  - `ct_valid` in RUN with a non-empty FIFO pops one parity vector.
  - It registers hit_k = popped_k ^ parity(ciphertext & mask_o_k).
  - On the following edge, each counter k increments by hit_k.
  - `ct_valid` outside RUN is ignored.
- Boundary conditions:
  - Underflow (`ct_valid` with an empty FIFO): the sample is ignored and nothing is counted or consumed.
  - Overflow (accept while the FIFO is full): the write is dropped but the message still counts as accepted. As a result, the run cannot reach DONE without a reset or restart, unless `LIN_MASK_COUNTER_STATUS_EN` is used to detect it.
  - Simultaneous push and pop on a full or empty FIFO is legal: the pop frees a slot, and a push to an empty FIFO is not poppable in the same cycle.
- Counters cannot overflow: the maximum count is NUM_MESSAGES, which fits in CNT_W.
- `rst_n` low mid-run aborts the run. All state returns to reset values on the next edge.

## Timing
- Reset values: `counter`=0, `valid`=0, `busy`=0, `msg_ready`=0. FIFO empty, state IDLE.
- `start` sampled at edge e: `busy` and `msg_ready` are high from e onward.
- Parity latency:
  - `ct_valid` at cycle t: hit registered at the end of t.
  - Counter updated at the end of t+1.
- Completion:
  - Final ciphertext at cycle t: `valid`=1 and `busy`=0 from cycle t+2.
  - `valid` holds until reset or the next `start`.
  - `valid` drops on the edge that samples the restart `start`.
- `msg_ready` falls on the edge that accepts the NUM_MESSAGES-th message.
- Throughput: one message and one ciphertext per cycle, sustained.

## Configuration
- `LIN_MASK_COUNTER_STATUS_EN` defined:
  - adds output `err` (2 bits): bit0 = sticky FIFO overflow, bit1 = sticky FIFO underflow;
  - both bits are cleared by reset and by `start`;
  - adds output `fifo_level` ($clog2(FIFO_DEPTH)+1 bits) giving the current occupancy.
- Undefined: neither port exists. Overflow and underflow behave identically but are silent.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, toggle `msg_valid`/`ct_valid` with no `start` → `counter`=0, `valid`=0, `msg_ready`=0 throughout.
- Single-mask reference run:
  - Setup: NUM_MASKS=1, NUM_MESSAGES=16, core latency 17, `mask_i`=64'h1584458925484615, `mask_o`=64'h0049845174789897, LFSR-style messages.
  - Expect: `counter` equals the software model count, and `valid` rises exactly 2 cycles after the 16th `ct_valid`.
- Multi-mask:
  - Setup: NUM_MASKS=4, masks {0, 1, 1<<63, all-ones} on both sides, ciphertext = message.
  - Expect: counters = {0, 0, 0, 0} after 1024 pairs.
  - Then mask_o_1 = 2 with message bit0 ^ bit1 = 1 every pair → counter_1 = 1024.
- Variable latency and backpressure:
  - Setup: `ct_valid` gaps of 0–5 random cycles, `msg_valid` bursts until `msg_ready` falls.
  - Expect: counts match the model, with exactly NUM_MESSAGES accepted.
- Boundaries:
  - FIFO_DEPTH=4 with 5 messages before any ciphertext → overflow; `err[0]`=1 when STATUS_EN is defined.
  - `ct_valid` with an empty FIFO → counter unchanged; `err[1]`=1 when STATUS_EN is defined.
- Restart and abort:
  - `start` in DONE → counters read 0 the next cycle and a new run completes.
  - `rst_n`=0 at message 500 → all outputs return to reset values in one edge.
